// File: rtl/credit_sequencer.sv
// -----------------------------------------------------------------------------
// credit_sequencer
//
// Purpose:
//   Sits between the merged button logic and the game core's start input.
//   Debounces the coin and start buttons and keeps a saturating credit count.
//   Drives the core's start input with a timed pulse, then waits for the core
//   to report an active game. If the game never starts, the credit is refunded.
//   Free-play mode starts a game without a credit and never refunds.
//
// Ports:
//   clk_sys     in   1  system clock, rising edge
//   reset_n     in   1  asynchronous active-low reset
//   coin_in     in   1  raw coin button (asynchronous level)
//   start_in    in   1  raw start button (level)
//   free_play   in   1  start needs/consumes no credit (synchronous level)
//   game_active in   1  core reports a game in progress
//   start_out   out  1  start pulse to the core
//   credits     out  4  current credit count
//   coin_ack    out  1  one-cycle strobe per accepted coin (also when saturated)
//   busy        out  1  high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module credit_sequencer #(
  parameter int DEBOUNCE_CYC    = 500000,
  parameter int START_PULSE_CYC = 2500000,
  parameter int TIMEOUT_CYC     = 50000000,
  parameter int MAX_CREDITS     = 9
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       coin_in,
  input  logic       start_in,
  input  logic       free_play,
  input  logic       game_active,
  output logic       start_out,
  output logic [3:0] credits,
  output logic       coin_ack,
  output logic       busy
);

  localparam int DBW     = $clog2(DEBOUNCE_CYC + 1);
  localparam int SEQ_MAX = (START_PULSE_CYC > TIMEOUT_CYC) ? START_PULSE_CYC : TIMEOUT_CYC;
  localparam int CW      = $clog2(SEQ_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  // Index 0 = coin, index 1 = start; both use an identical filter path.
  logic [1:0] w_raw;
  logic [1:0] w_ev;

  assign w_raw = {start_in, coin_in};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_db
      logic           r_s1;
      logic           r_s2;
      logic           r_db;
      logic           r_db_q;
      logic [DBW-1:0] r_cnt;

      always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
          r_s1   <= 1'b0;
          r_s2   <= 1'b0;
          r_db   <= 1'b0;
          r_db_q <= 1'b0;
          r_cnt  <= '0;
        end else begin
          r_s1   <= w_raw[gi];
          r_s2   <= r_s1;
          r_db_q <= r_db;
          // Any sample agreeing with the accepted level restarts the count,
          // so only an unbroken run of DEBOUNCE_CYC differing samples wins.
          if (r_s2 == r_db) begin
            r_cnt <= '0;
          end else if (r_cnt == DBW'(DEBOUNCE_CYC - 1)) begin
            r_db  <= r_s2;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      assign w_ev[gi] = r_db & ~r_db_q;
    end
  endgenerate

  logic          w_coin_ev;
  logic          w_start_ev;
  logic [4:0]    w_cred_coin;
  logic          w_accept;
  logic          w_take;
  logic          w_refund;
  logic [4:0]    w_cred_sum;
  logic [3:0]    w_cred_next;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_taken;

  assign w_coin_ev  = w_ev[0];
  assign w_start_ev = w_ev[1];

  // Credit count after this cycle's coin, before any start/refund.
  assign w_cred_coin = {1'b0, credits} + {4'b0, w_coin_ev};

  assign w_accept = (r_state == S_IDLE) && w_start_ev && !game_active &&
                    (free_play || (w_cred_coin != 5'd0));
  assign w_take   = w_accept && !free_play;
  assign w_refund = (r_state == S_WAIT) && !game_active && (r_cnt == '0) && r_taken;

  // Summed 5 bits wide so coin+refund cannot wrap before the clamp; a take
  // only happens when w_cred_coin is nonzero, so the subtraction never goes
  // below zero.
  assign w_cred_sum  = w_cred_coin + {4'b0, w_refund} - {4'b0, w_take};
  assign w_cred_next = (w_cred_sum > 5'(MAX_CREDITS)) ? 4'(MAX_CREDITS) : w_cred_sum[3:0];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_taken   <= 1'b0;
      start_out <= 1'b0;
      busy      <= 1'b0;
      credits   <= 4'd0;
      coin_ack  <= 1'b0;
    end else begin
      credits  <= w_cred_next;
      coin_ack <= w_coin_ev;

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state   <= S_PULSE;
            r_cnt     <= CW'(START_PULSE_CYC - 1);
            r_taken   <= !free_play;
            start_out <= 1'b1;
            busy      <= 1'b1;
          end
        end

        S_PULSE: begin
          if (r_cnt == '0) begin
            r_state   <= S_WAIT;
            r_cnt     <= CW'(TIMEOUT_CYC - 1);
            start_out <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        S_WAIT: begin
          if (game_active) begin
            r_state <= S_IDLE;
            r_taken <= 1'b0;
            busy    <= 1'b0;
          end else if (r_cnt == '0) begin
            // Refund, if any, is applied through w_refund in this same cycle.
            r_state <= S_IDLE;
            r_taken <= 1'b0;
            busy    <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        default: begin
          r_state   <= S_IDLE;
          start_out <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/credit_sequencer.md
Name: credit_sequencer

Overview:
- Sits between the merged keyboard/joystick button logic and the game core's start input in the arcade top level.
- Debounces the coin and start controls and keeps a saturating credit count.
- Sequences the core's start input as a timed pulse, then waits for the core to report an active game.
- Refunds the credit if the core never starts, and supports a free-play mode.

Parameters:
- DEBOUNCE_CYC, 500000: consecutive stable samples needed to accept a new button level; 10 ms at 50 MHz.
- START_PULSE_CYC, 2500000: length of the start_out high pulse, in cycles.
- TIMEOUT_CYC, 50000000: maximum wait for game_active to rise after the pulse ends.
- MAX_CREDITS, 9: saturation value of the credit count, range 1..15.

Ports:
- clk_sys  in  1  system clock; all logic runs on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- coin_in  in  1  raw coin button, level, asynchronous to the block.
- start_in  in  1  raw start button, level.
- free_play  in  1  when 1, a start needs no credit and consumes none; level, synchronous.
- game_active  in  1  from the core; 1 while a game is in progress.
- start_out  out  1  start signal to the core.
- credits  out  4  current credit count.
- coin_ack  out  1  one-cycle strobe on each accepted coin, including saturated coins.
- busy  out  1  1 while the state is not IDLE.

Behaviour:
- Reset values: start_out=0, credits=0, coin_ack=0, busy=0, state=IDLE. Debounced levels and debounce counters reset to 0.
- Input synchronisers:
  - coin_in and start_in each pass through a 2-flop synchroniser.
  - No synchroniser on free_play or game_active.
- Debounce, per input:
  - A counter clears whenever the synchronised level equals the debounced level.
  - Otherwise it increments.
  - On reaching DEBOUNCE_CYC-1 while different, the debounced level takes the synchronised level and the counter clears.
  - A rising edge of the debounced level produces a one-cycle event: coin_ev or start_ev.
  - Event latency from a stable raw input: 2 synchroniser cycles + DEBOUNCE_CYC cycles + 1 edge-detect register.
- Coin handling:
  - On coin_ev, credits increments, saturating at MAX_CREDITS.
  - coin_ack pulses in the same cycle the credit register updates.
- State machine:
  - IDLE -> PULSE when start_ev && !game_active && (free_play || credits_eff>0).
    - credits_eff is the credit count after this cycle's coin increment.
    - On this transition, if !free_play, credits decrements.
    - start_ev in IDLE that fails the condition is discarded, not queued.
  - PULSE: start_out=1 for exactly START_PULSE_CYC cycles; the counter is loaded on entry. Then -> WAIT.
  - WAIT:
    - If game_active=1 -> IDLE; the credit stays consumed.
    - If game_active stays 0 for TIMEOUT_CYC cycles -> IDLE. If the credit was taken, a refund increments credits (saturating); in free play there is no refund.
    - A "credit taken" flag is captured at the PULSE transition.
  - start_ev arriving in PULSE or WAIT is ignored.
  - coin_ev is accepted in every state.
- Simultaneous events:
  - coin_ev and an accepted start_ev in the same cycle: net credit change is 0. This includes the case credits=0 before the cycle.
  - coin_ev and refund in the same cycle: +2, then saturate at MAX_CREDITS.
- Arithmetic:
  - The credit update is computed 5 bits wide, then clamped to MAX_CREDITS.
  - credits never underflows below 0.
- Toggling free_play mid-sequence does not change the credit-taken flag already captured.
- Reset asserted mid-operation: all state clears immediately and asynchronously. start_out drops with no minimum pulse width, and credits are lost.
- game_active going high while in IDLE has no effect.
- All outputs are registered.

Test Plan:
Bench parameters are DEBOUNCE_CYC=4, START_PULSE_CYC=8, TIMEOUT_CYC=32, MAX_CREDITS=3.
1. Coin and saturation: press coin 5 times, each held 10 cycles with 10 released -> credits goes 1,2,3,3,3; 5 coin_ack strobes.
2. Bounce filtering: coin_in toggles every 2 cycles for 20 cycles, then settles high -> exactly one coin_ev and credits=1.
3. Normal start: credits=2, press start, game_active rises 5 cycles after start_out falls -> start_out high for exactly 8 cycles; credits=1; busy falls the cycle after game_active rises.
4. Timeout refund: credits=1, press start, game_active held at 0 -> credits=0 during PULSE/WAIT; 32 cycles after the pulse ends, credits=1 and the state is IDLE.
5. No credit / free play: credits=0, free_play=0, press start -> no start_out. With free_play=1 -> 8-cycle start_out, credits stays 0, no refund on timeout.
6. Simultaneous events and reset: coin_ev and start_ev in the same cycle with credits=0 -> credits stays 0 and PULSE is entered. Then reset_n pulled low 3 cycles into PULSE -> start_out=0 and credits=0 immediately, with no clock edge needed.
